dual_port_ram: RTL and testbench
================================

// Module: dual_port_ram
// PURPOSE
//   True dual-port synchronous RAM, two independent read/write ports (A, B) on one clock.
//   Used as video RAM: the character-write path stores packed
//   {fg[23:0], bg[23:0], code[7:0]} words on port A.
//   The display scan path reads them on port B.
//   Depth = 2**ADDR_WIDTH words; contents zero at power-up.
// PARAMETERS
//   ADDR_WIDTH  11  address bits per port; depth = 2**ADDR_WIDTH (2048 words at default)
//   DATA_WIDTH  56  word width; default holds {fg24, bg24, code8}
// PORTS
//   clk        in   1           single clock; all activity on rising edge
//   rst        in   1           synchronous, active-high reset
//   address_a  in   ADDR_WIDTH  port A word address
//   wren_a     in   1           port A write enable
//   data_a     in   DATA_WIDTH  port A write data
//   rden_a     in   1           port A read enable
//   q_a        out  DATA_WIDTH  port A registered read data
//   address_b  in   ADDR_WIDTH  port B word address
//   wren_b     in   1           port B write enable
//   data_b     in   DATA_WIDTH  port B write data
//   rden_b     in   1           port B read enable
//   q_b        out  DATA_WIDTH  port B registered read data
// BEHAVIOUR
//   - Clock/reset: one clock, clk; reset is synchronous and active-high (rst).
//   - Reset: at a rising edge with rst=1, q_a and q_b become 0.
//     Memory contents are NOT cleared by reset.
//     Writes requested in the same cycle as rst=1 are ignored.
//   - Power-up: every memory word is 0, and q_a = q_b = 0.
//   - Write: at a rising edge with wren_x=1 and rst=0, mem[address_x] <= data_x.
//   - Read latency is 1 cycle.
//     At a rising edge with rden_x=1 and rst=0, q_x <= mem[address_x].
//     The value returned is the memory content before that edge's writes.
//   - rden_x=0: q_x holds its previous value.
//   - Same-port read-during-write (wren_x=rden_x=1): q_x returns the OLD word; the new word is stored.
//   - Cross-port read of an address the other port writes in the same cycle: the reader gets the OLD word.
//   - Both ports write the same address in the same cycle: port A's data is stored and port B's write is dropped.
//   - Different addresses: both ports operate fully independently, with no stalls.
//   - Port A and port B may both read and both write in the same cycle.
//   - Addresses are exactly ADDR_WIDTH bits wide.
//     Wider driving expressions are truncated to their low ADDR_WIDTH bits, so addresses wrap modulo depth.
//   - No handshake and no busy signal: one access per port per cycle, always accepted.
//   - Outputs are driven only from registers; there is no combinational path from inputs to q_a or q_b.
// TESTING
//   1. Power-up, rden_b=1, sweep addresses 0..2047 -> q_b = 0 for every word, 1 cycle after each address.
//   2. Write A: addr 5, data 56'hFFFFFF_000000_41.
//      Next cycle read B at addr 5 -> q_b = 56'hFFFFFF_000000_41 one cycle after the read edge.
//   3. Same-edge A write of 0x12 and B read at addr 9 (old value 0x34) -> q_b = 0x34.
//      The following read returns 0x12.
//   4. Simultaneous writes to addr 7: A = 0xAA, B = 0xBB -> a later read of addr 7 returns 0xAA.
//   5. Load q_b = 0x55, then drop rden_b to 0 and change address_b -> q_b stays 0x55.
//      Assert rst for 1 cycle -> q_b = 0.
//      A later read of the stored word still returns its data, showing reset does not clear memory.
//   6. Address wrap: write 0x77 at addr 2047 via port A.
//      Read 2047 via port B -> 0x77.
//      Read addr 0 -> 0, because no aliasing occurs inside the valid range.

Source files
------------

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - true dual-port synchronous RAM with registered read data on one clock
// Port A wins same-address write collisions; reads always return the word as it was before the edge.
module dual_port_ram #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 56
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address_a,
   input  logic                  wren_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic                  rden_a,
   output logic [DATA_WIDTH-1:0] q_a,
   input  logic [ADDR_WIDTH-1:0] address_b,
   input  logic                  wren_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   input  logic                  rden_b,
   output logic [DATA_WIDTH-1:0] q_b
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Declaration initialisers give the zeroed power-up image; reset deliberately leaves memory alone.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
   logic [DATA_WIDTH-1:0] q_a_q = '0;
   logic [DATA_WIDTH-1:0] q_b_q = '0;
   logic [DATA_WIDTH-1:0] q_a_d;
   logic [DATA_WIDTH-1:0] q_b_d;
   logic                  we_a;
   logic                  we_b;

   always_comb begin
      we_a = wren_a && !rst;
      we_b = wren_b && !rst && !(wren_a && (address_a == address_b));
   end

   // mem_q is sampled before this edge's writes land, giving old-data read-during-write.
   always_comb begin
      q_a_d = q_a_q;
      q_b_d = q_b_q;
      if (rst) begin
         q_a_d = '0;
         q_b_d = '0;
      end else begin
         if (rden_a) q_a_d = mem_q[address_a];
         if (rden_b) q_b_d = mem_q[address_b];
      end
   end

   always_ff @(posedge clk) begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
      if (we_a) mem_q[address_a] <= data_a;
      if (we_b) mem_q[address_b] <= data_b;
   end

   assign q_a = q_a_q;
   assign q_b = q_b_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - directed self-checking bench for dual_port_ram
module tb_dual_port_ram;

   localparam int AW = 11;
   localparam int DW = 56;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] address_a = '0;
   logic          wren_a = 1'b0;
   logic [DW-1:0] data_a = '0;
   logic          rden_a = 1'b0;
   logic [DW-1:0] q_a;
   logic [AW-1:0] address_b = '0;
   logic          wren_b = 1'b0;
   logic [DW-1:0] data_b = '0;
   logic          rden_b = 1'b0;
   logic [DW-1:0] q_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .address_a (address_a),
      .wren_a    (wren_a),
      .data_a    (data_a),
      .rden_a    (rden_a),
      .q_a       (q_a),
      .address_b (address_b),
      .wren_b    (wren_b),
      .data_b    (data_b),
      .rden_b    (rden_b),
      .q_b       (q_b)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      wren_a = 1'b0; rden_a = 1'b0;
      wren_b = 1'b0; rden_b = 1'b0;
      rst    = 1'b0;
   endtask

   task automatic test_powerup();
      int bad;
      #1;
      checks++;
      if (q_a !== '0) begin errors++; $display("FAIL powerup_q_a: got %h expected 0", q_a); end
      checks++;
      if (q_b !== '0) begin errors++; $display("FAIL powerup_q_b: got %h expected 0", q_b); end
      bad = 0;
      rden_b = 1'b1;
      for (int i = 0; i < 2 ** AW; i++) begin
         address_b = AW'(i);
         step();
         checks++;
         if (q_b !== '0) begin
            errors++;
            if (bad < 8) $display("FAIL powerup_sweep addr %0d: got %h expected 0", i, q_b);
            bad++;
         end
      end
      idle();
   endtask

   task automatic test_write_read();
      address_a = 11'd5; data_a = 56'hFFFFFF_000000_41; wren_a = 1'b1;
      step();
      idle();
      address_b = 11'd5; rden_b = 1'b1;
      step();
      checks++;
      if (q_b !== 56'hFFFFFF_000000_41) begin
         errors++; $display("FAIL write_read: got %h expected ffffff00000041", q_b);
      end
      idle();
   endtask

   task automatic test_read_during_write();
      address_a = 11'd9; data_a = 56'h34; wren_a = 1'b1;
      step();
      data_a = 56'h12; address_b = 11'd9; rden_b = 1'b1;
      step();
      checks++;
      if (q_b !== 56'h34) begin errors++; $display("FAIL cross_rdw_old: got %h expected 34", q_b); end
      wren_a = 1'b0;
      step();
      checks++;
      if (q_b !== 56'h12) begin errors++; $display("FAIL cross_rdw_new: got %h expected 12", q_b); end
      idle();
      data_a = 56'h56; wren_a = 1'b1; rden_a = 1'b1;
      step();
      checks++;
      if (q_a !== 56'h12) begin errors++; $display("FAIL same_port_rdw_old: got %h expected 12", q_a); end
      wren_a = 1'b0;
      step();
      checks++;
      if (q_a !== 56'h56) begin errors++; $display("FAIL same_port_rdw_new: got %h expected 56", q_a); end
      idle();
   endtask

   task automatic test_collision();
      address_a = 11'd7; data_a = 56'hAA; wren_a = 1'b1;
      address_b = 11'd7; data_b = 56'hBB; wren_b = 1'b1;
      step();
      idle();
      rden_a = 1'b1; rden_b = 1'b1;
      step();
      checks++;
      if (q_b !== 56'hAA) begin errors++; $display("FAIL collision_b: got %h expected aa", q_b); end
      checks++;
      if (q_a !== 56'hAA) begin errors++; $display("FAIL collision_a: got %h expected aa", q_a); end
      idle();
   endtask

   task automatic test_independent();
      address_a = 11'd100; data_a = 56'h1111; wren_a = 1'b1;
      address_b = 11'd200; data_b = 56'h2222; wren_b = 1'b1;
      step();
      idle();
      address_a = 11'd200; rden_a = 1'b1;
      address_b = 11'd100; rden_b = 1'b1;
      step();
      checks++;
      if (q_a !== 56'h2222) begin errors++; $display("FAIL independent_a: got %h expected 2222", q_a); end
      checks++;
      if (q_b !== 56'h1111) begin errors++; $display("FAIL independent_b: got %h expected 1111", q_b); end
      idle();
   endtask

   task automatic test_hold_reset();
      address_a = 11'd20; data_a = 56'h55; wren_a = 1'b1;
      step();
      idle();
      address_b = 11'd20; rden_b = 1'b1;
      address_a = 11'd20; rden_a = 1'b1;
      step();
      idle();
      address_b = 11'd21; address_a = 11'd5;
      step();
      checks++;
      if (q_b !== 56'h55) begin errors++; $display("FAIL hold_q_b: got %h expected 55", q_b); end
      checks++;
      if (q_a !== 56'h55) begin errors++; $display("FAIL hold_q_a: got %h expected 55", q_a); end
      rst = 1'b1;
      address_a = 11'd20; data_a = 56'h99; wren_a = 1'b1;
      step();
      checks++;
      if (q_b !== '0) begin errors++; $display("FAIL reset_q_b: got %h expected 0", q_b); end
      checks++;
      if (q_a !== '0) begin errors++; $display("FAIL reset_q_a: got %h expected 0", q_a); end
      idle();
      address_b = 11'd20; rden_b = 1'b1;
      step();
      checks++;
      if (q_b !== 56'h55) begin errors++; $display("FAIL reset_keeps_mem: got %h expected 55", q_b); end
      idle();
   endtask

   task automatic test_wrap();
      address_a = 11'd2047; data_a = 56'h77; wren_a = 1'b1;
      step();
      idle();
      address_b = 11'd2047; rden_b = 1'b1;
      step();
      checks++;
      if (q_b !== 56'h77) begin errors++; $display("FAIL wrap_top: got %h expected 77", q_b); end
      address_b = 11'd0;
      step();
      checks++;
      if (q_b !== '0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", q_b); end
      idle();
   endtask

   initial begin
      test_powerup();
      test_write_read();
      test_read_during_write();
      test_collision();
      test_independent();
      test_hold_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
